// File: rtl/sram_bus_sequencer.sv
// Sequences single-cycle CPU requests into SETUP / ACCESS(+wait states) / HOLD SRAM bus cycles.
// Define SEQ_B2B_EN to allow a new request to be accepted during HOLD (back-to-back accesses).
module sram_bus_sequencer #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_from_CPU,
  input  logic [DATA_W-1:0] Data_to_CPU,
  output logic              busy
);

  localparam int H = DATA_W / 2;
  localparam logic [7:0] RD_CNT = 8'(RD_WAIT);
  localparam logic [7:0] WR_CNT = 8'(WR_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              accept;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_be;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [DATA_W-1:0] cur_wdata;
  logic [1:0]        cur_be;

  logic [ADDR_W-1:0] addr_d;
  logic              ce_d, ub_d, lb_d, oe_d, we_d, rsp_valid_d;
  logic [DATA_W-1:0] dout_d, rdata_d;

`ifdef SEQ_B2B_EN
  assign req_ready = Reset && ((state == IDLE) || (state == HOLD));
`else
  assign req_ready = Reset && (state == IDLE);
`endif
  assign busy   = (state != IDLE);
  assign accept = req_valid && req_ready;

  // A freshly accepted request drives the SETUP edge directly; afterwards the latched copy is used.
  assign cur_addr  = accept ? req_addr  : lat_addr;
  assign cur_we    = accept ? req_we    : lat_we;
  assign cur_wdata = accept ? req_wdata : lat_wdata;
  assign cur_be    = accept ? req_be    : lat_be;

  always_ff @(posedge Clk) begin
    if (accept) begin
      lat_addr  <= req_addr;
      lat_we    <= req_we;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP)
        cnt <= lat_we ? WR_CNT : RD_CNT;
      else if ((state == ACCESS) && (cnt != '0))
        cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered-output values for the cycle the FSM is about to enter.
  always_comb begin
    addr_d      = ADDR;
    ce_d        = 1'b1;
    ub_d        = 1'b1;
    lb_d        = 1'b1;
    oe_d        = 1'b1;
    we_d        = 1'b1;
    dout_d      = Data_from_CPU;
    rsp_valid_d = 1'b0;
    rdata_d     = rsp_rdata;
    case (state_nxt)
      SETUP: begin
        addr_d = cur_addr;
        ce_d   = 1'b0;
        ub_d   = ~cur_be[1];
        lb_d   = ~cur_be[0];
        if (cur_we) dout_d = cur_wdata;
      end
      ACCESS: begin
        ce_d = 1'b0;
        ub_d = ~lat_be[1];
        lb_d = ~lat_be[0];
        oe_d = lat_we;
        we_d = ~lat_we;
      end
      HOLD: begin
        ce_d        = 1'b0;
        ub_d        = UB;
        lb_d        = LB;
        rsp_valid_d = 1'b1;
        if (!lat_we) begin
          rdata_d[DATA_W-1:H] = lat_be[1] ? Data_to_CPU[DATA_W-1:H] : '0;
          rdata_d[H-1:0]      = lat_be[0] ? Data_to_CPU[H-1:0]      : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ADDR          <= '0;
      CE            <= 1'b1;
      UB            <= 1'b1;
      LB            <= 1'b1;
      OE            <= 1'b1;
      WE            <= 1'b1;
      Data_from_CPU <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      ADDR          <= addr_d;
      CE            <= ce_d;
      UB            <= ub_d;
      LB            <= lb_d;
      OE            <= oe_d;
      WE            <= we_d;
      Data_from_CPU <= dout_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// Bench for sram_bus_sequencer: directed table, held-request, reset and random traffic against an SRAM model.
module tb_sram_bus_sequencer;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [1:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] ADDR;
  logic              CE, UB, LB, OE, WE;
  logic [DATA_W-1:0] Data_from_CPU;
  logic [DATA_W-1:0] Data_to_CPU;
  logic              busy;

  sram_bus_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] sram    [logic [19:0]];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] last_rd = 16'h0000;

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sram_rd(input logic [19:0] a);
    return sram.exists(a) ? sram[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a, input logic [1:0] be);
    logic [15:0] m;
    m = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    return {be[1] ? m[15:8] : 8'h00, be[0] ? m[7:0] : 8'h00};
  endfunction

  task automatic ref_wr(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] m;
    m = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    if (be[1]) m[15:8] = d[15:8];
    if (be[0]) m[7:0]  = d[7:0];
    ref_mem[a] = m;
  endtask

  // Behavioural asynchronous SRAM on the strobe side.
  always @(posedge Clk) begin
    if (Reset && !CE && !WE) begin
      logic [15:0] t;
      t = sram_rd(ADDR);
      if (!UB) t[15:8] = Data_from_CPU[15:8];
      if (!LB) t[7:0]  = Data_from_CPU[7:0];
      sram[ADDR] = t;
    end
  end

  always @(negedge Clk)
    Data_to_CPU = (!CE && !OE) ? sram_rd(ADDR) : 16'($urandom);

  // Called at a negedge with the sequencer idle; returns at the negedge of cycle WAIT+4.
  task automatic do_txn(input bit we, input logic [19:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] exp_rd, input bit keep_valid);
    int w;
    int n;
    w = we ? WR_WAIT : RD_WAIT;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    req_we = 1'($urandom); req_addr = 20'($urandom); req_wdata = 16'($urandom); req_be = 2'($urandom);
    if (!keep_valid) req_valid = 1'b0;
    if (we) ref_wr(addr, wdata, be);
    for (int k = 1; k <= w + 3; k++) begin
      @(negedge Clk);
      check("busy", busy, 1);
      check("CE", CE, 0);
      check("UB", UB, !be[1]);
      check("LB", LB, !be[0]);
      check("ADDR", ADDR, addr);
      check("OE", OE, !(!we && k >= 2 && k <= w + 2));
      check("WE", WE, !(we && k >= 2 && k <= w + 2));
      check("rsp_valid", rsp_valid, k == w + 3);
`ifdef SEQ_B2B_EN
      check("req_ready_busy", req_ready, k == w + 3);
`else
      check("req_ready_busy", req_ready, 0);
`endif
      if (we) check("Data_from_CPU", Data_from_CPU, wdata);
      if (k == w + 3) begin
        if (!we) begin
          check("rsp_rdata", rsp_rdata, exp_rd);
          last_rd = exp_rd;
        end else begin
          check("rsp_rdata_hold", rsp_rdata, last_rd);
        end
      end
    end
    @(negedge Clk);
    check("ready_after", req_ready, 1);
    check("CE_idle", CE, 1);
    check("UB_idle", UB, 1);
    check("LB_idle", LB, 1);
    check("busy_idle", busy, 0);
    check("rsp_valid_idle", rsp_valid, 0);
    check("ADDR_idle_hold", ADDR, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 20'h0FFFF, 16'h1234, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 20'h00010, 16'hBEEF, 2'b11, 16'h0000};
    vecs[2]  = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF};
    vecs[3]  = '{1'b0, 20'h00010, 16'h0000, 2'b01, 16'h00EF};
    vecs[4]  = '{1'b0, 20'h00010, 16'h0000, 2'b10, 16'hBE00};
    vecs[5]  = '{1'b0, 20'h00010, 16'h0000, 2'b00, 16'h0000};
    vecs[6]  = '{1'b1, 20'hFFFFF, 16'hA55A, 2'b11, 16'h0000};
    vecs[7]  = '{1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'hA55A};
    vecs[8]  = '{1'b1, 20'h00010, 16'h1177, 2'b10, 16'h0000};
    vecs[9]  = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'h11EF};
    vecs[10] = '{1'b0, 20'h0FFFF, 16'h0000, 2'b11, 16'h1234};
    vecs[11] = '{1'b1, 20'h00000, 16'hFFFF, 2'b00, 16'h0000};
    vecs[12] = '{1'b0, 20'h00000, 16'h0000, 2'b11, 16'h0000};

    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_CE", CE, 1);
    check("rst_UB", UB, 1);
    check("rst_LB", LB, 1);
    check("rst_OE", OE, 1);
    check("rst_WE", WE, 1);
    check("rst_ADDR", ADDR, 0);
    check("rst_Data_from_CPU", Data_from_CPU, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    Reset = 1'b1;
    #1 check("ready_after_rst", req_ready, 1);
    @(negedge Clk);

    foreach (vecs[i])
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd, 1'b0);

`ifndef SEQ_B2B_EN
    // Request held through a busy access is taken only once the sequencer is idle again.
    do_txn(1'b0, 20'h00010, 16'h0000, 2'b11, 16'h11EF, 1'b1);
    do_txn(1'b0, 20'h0FFFF, 16'h0000, 2'b11, 16'h1234, 1'b0);
`endif

    for (int r = 0; r < 40; r++) begin
      bit          we;
      logic [19:0] a;
      logic [15:0] d;
      logic [1:0]  be;
      we = 1'($urandom_range(0, 1));
      a  = 20'h00100 + 20'($urandom_range(0, 7));
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      do_txn(we, a, d, be, ref_rd(a, be), 1'b0);
    end

`ifdef SEQ_B2B_EN
    begin
      int c;
      req_we = 1'b1; req_addr = 20'h00020; req_wdata = 16'h1111; req_be = 2'b11; req_valid = 1'b1;
      check("b2b_ready0", req_ready, 1);
      @(posedge Clk);
      #1;
      ref_wr(20'h00020, 16'h1111, 2'b11);
      req_addr = 20'h00021; req_wdata = 16'h2222;
      for (c = 1; c <= 2 * WR_WAIT + 6; c++) begin
        @(negedge Clk);
        check("b2b_CE", CE, 0);
        check("b2b_rsp_valid", rsp_valid, (c == WR_WAIT + 3) || (c == 2 * WR_WAIT + 6));
        if (c == WR_WAIT + 4) check("b2b_ADDR2", ADDR, 20'h00021);
        if (c == WR_WAIT + 3) begin
          check("b2b_ready_hold", req_ready, 1);
          @(posedge Clk);
          #1 req_valid = 1'b0;
          ref_wr(20'h00021, 16'h2222, 2'b11);
        end
      end
      @(negedge Clk);
      check("b2b_CE_idle", CE, 1);
      do_txn(1'b0, 20'h00021, 16'h0000, 2'b11, 16'h2222, 1'b0);
    end
`endif

    // Reset in the middle of a write ACCESS: strobes release immediately and no response follows.
    req_we = 1'b1; req_addr = 20'h00777; req_wdata = 16'h5555; req_be = 2'b11; req_valid = 1'b1;
    check("rst_seq_ready", req_ready, 1);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_seq_WE_low", WE, 0);
    #2 Reset = 1'b0;
    #1;
    check("rst_async_WE", WE, 1);
    check("rst_async_OE", OE, 1);
    check("rst_async_CE", CE, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", req_ready, 0);
    @(negedge Clk);
    Reset = 1'b1;
    last_rd = 16'h0000;
    #1 check("rst_release_ready", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("rst_no_rsp", rsp_valid, 0);
      check("rst_idle_busy", busy, 0);
    end
    do_txn(1'b0, 20'h0FFFF, 16'h0000, 2'b01, 16'h0034, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
